octree_bfs_engine: RTL and testbench
====================================

# octree_bfs_engine

Parametrised breadth-first traversal engine for the octree branch table held in BRAM. From a root address it fetches branch nodes and derives an 8-bit occupancy code per node. Branch children go into a circular FIFO queue, and codes are packed MSB-first into bursts for the DDR writer, which accepts them over a valid/ready handshake. Sits between the octree-build BRAM and the AXI DDR write path.

## Interface
- ADDR_W, 9, BRAM address width; also visited-bitmap depth 2^ADDR_W
- PTR_W, 16, width of one child pointer in a node word
- BURST_W, 64, output burst width; must be a multiple of 8; codes per burst = BURST_W/8
- QUEUE_DEPTH, 512, FIFO entries; must be a power of two
- BRAM_LAT, 1, BRAM read latency in cycles (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_root_addr  in  ADDR_W  root node address
- o_rd_en  out  1  BRAM read strobe
- o_rd_addr  out  ADDR_W  BRAM read address
- i_rd_data  in  8*PTR_W  node word; child c is at [PTR_W*c +: PTR_W]
- o_burst_data  out  BURST_W  packed occupancy codes
- o_burst_valid  out  1  burst available
- i_burst_ready  in  1  DDR writer accepts the burst
- o_burst_last  out  1  final burst of the traversal
- o_busy  out  1  high whenever state ≠ IDLE
- o_done  out  1  one-cycle completion pulse
- o_overflow  out  1  sticky queue-overflow flag; cleared on the next accepted start
- o_node_count  out  16  number of codes emitted, saturating at 0xFFFF

## Operation
- Child pointer semantics:
  - 0: empty.
  - 1: leaf. Occupied, not enqueued.
  - ≥2: branch. Occupied and enqueued; only the low ADDR_W bits are used.
- Occupancy bit c = (ptr_c ≠ 0).
- FSM states: IDLE, FETCH, WAIT, SCAN, POP, FLUSH, DONE.
- IDLE:
  - On i_start with i_root_addr ≥ 2, latch the root and go to FETCH.
  - On i_start with i_root_addr < 2, go to DONE with no burst.
- FETCH: o_rd_en=1 and o_rd_addr = current address for exactly one cycle, then WAIT for BRAM_LAT cycles.
- WAIT exit: capture i_rd_data and write the occupancy byte into the pack register at slot = code index mod (BURST_W/8). Slot 0 is the MSB byte. Increment o_node_count.
- SCAN: 8 cycles examining child 7 down to child 0, one per cycle; each branch pointer is pushed to the queue.
  - Push while the queue is full: the pointer is dropped, o_overflow is set, and the traversal continues.
- After SCAN:
  - If the pack register is full, go to FLUSH (o_burst_last=0) and then POP.
  - Otherwise go directly to POP.
- POP:
  - Queue empty: if the pack register holds ≥1 code, go to FLUSH with the unused bytes zero and o_burst_last=1, then DONE. Otherwise set o_burst_last on the previous burst…
  - Rule to resolve that case: the last full burst is held in FLUSH with o_burst_last=1. To allow this, a full pack register is flushed lazily, at the next POP, once the queue state is known.
  - Queue not empty: dequeue one address per cycle and go to FETCH.
- FLUSH: o_burst_valid=1. o_burst_data and o_burst_last stay stable until i_burst_ready; transfer occurs in the cycle where both are high.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored.

## Timing
- Reset values: o_rd_en=0, o_rd_addr=0, o_burst_data=0, o_burst_valid=0, o_burst_last=0, o_busy=0, o_done=0, o_overflow=0, o_node_count=0. Queue pointers, pack register, visited bitmap and FSM are all cleared.
- Reset mid-traversal aborts immediately; no partial burst is emitted.
- Per-node cost, no stall: 1 POP + 1 FETCH + BRAM_LAT WAIT + 8 SCAN cycles. With BRAM_LAT=1 that is 11 cycles.
- First o_rd_en occurs the cycle after i_start.
- Queue: read/write pointers of log2(QUEUE_DEPTH) bits with wrap-around, plus an occupancy counter of log2(QUEUE_DEPTH)+1 bits. Push and pop never occur in the same cycle.
- Flush stall is unbounded; FSM state and all outputs hold while i_burst_ready=0.

## Configuration
- OCTREE_BFS_VISITED_FILTER_EN defined:
  - A 2^ADDR_W-bit visited bitmap is set at FETCH.
  - POP discards an already-visited address in 1 cycle, with no fetch and no code.
  - The bitmap clears at start.
- OCTREE_BFS_VISITED_FILTER_EN undefined: no bitmap; every dequeued address is fetched and emits a code.

## Test plan
- Root 2 with ptr7=3, ptr5=1, ptr0=4; nodes 3 and 4 are all-zero → codes 0xA1, 0x00, 0x00 → single burst 0xA100_0000_0000_0000 with o_burst_last=1, o_node_count=3, o_done pulse, o_overflow=0.
- 9-node tree (root with 8 branch children, all empty), i_burst_ready low for 20 cycles at the first flush → first burst holds root code 0xFF plus seven 0x00 codes, stable throughout; second burst is 0x00 then zero padding with last=1; o_node_count=9.
- Nodes 3 and 4 both point to node 5 → with the macro defined: 4 codes, 5 fetched once. With the macro undefined: 5 codes.
- QUEUE_DEPTH=4, root with 8 branch children → o_overflow=1, only 4 children fetched, o_node_count=5, traversal still ends with o_done.
- i_rst asserted during SCAN → all outputs at reset values the same cycle. A subsequent start with root 2 reproduces the first scenario exactly.
- i_start with i_root_addr=1 → o_done high on the following cycle, o_burst_valid never asserted, o_node_count=0.

Source files
------------

// File: rtl/octree_bfs_engine.sv
// Breadth-first walker over the octree branch table, emitting MSB-first packed occupancy bursts.
// Define OCTREE_BFS_VISITED_FILTER_EN to skip nodes already fetched during the current traversal.
module octree_bfs_engine #(
    parameter int ADDR_W      = 9,
    parameter int PTR_W       = 16,
    parameter int BURST_W     = 64,
    parameter int QUEUE_DEPTH = 512,
    parameter int BRAM_LAT    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_root_addr,
    output logic                 o_rd_en,
    output logic [ADDR_W-1:0]    o_rd_addr,
    input  logic [8*PTR_W-1:0]   i_rd_data,
    output logic [BURST_W-1:0]   o_burst_data,
    output logic                 o_burst_valid,
    input  logic                 i_burst_ready,
    output logic                 o_burst_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [15:0]          o_node_count
);

    localparam int NCODES = BURST_W / 8;
    localparam int CNT_W  = $clog2(NCODES + 1);
    localparam int QW     = $clog2(QUEUE_DEPTH);
    localparam int LAT_W  = $clog2(BRAM_LAT + 1);

    localparam logic [CNT_W-1:0] PACK_FULL = CNT_W'(NCODES);
    localparam logic [QW:0]      Q_FULL    = (QW+1)'(QUEUE_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(BRAM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SCAN,
        POP,
        FLUSH,
        DONE
    } state_t;

    state_t               state_q;
    logic [8*PTR_W-1:0]   node_q;
    logic [2:0]           scan_idx_q;
    logic [LAT_W-1:0]     wait_cnt_q;
    logic [BURST_W-1:0]   pack_q;
    logic [CNT_W-1:0]     pack_cnt_q;
    logic [QW-1:0]        wr_ptr_q;
    logic [QW-1:0]        rd_ptr_q;
    logic [QW:0]          q_count_q;
    logic [ADDR_W-1:0]    queue_mem [QUEUE_DEPTH];

    logic                 rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [BURST_W-1:0]   burst_data_q;
    logic                 burst_valid_q;
    logic                 burst_last_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overflow_q;
    logic [15:0]          node_count_q;

`ifdef OCTREE_BFS_VISITED_FILTER_EN
    logic [(1<<ADDR_W)-1:0] visited_q;
`endif

    logic [7:0]           occ_code;
    logic [PTR_W-1:0]     scan_ptr;
    logic                 scan_branch;
    logic                 q_full;
    logic                 q_empty;
    logic                 push_en;
    logic [ADDR_W-1:0]    head_addr;
    logic                 head_seen;

    always_comb begin
        occ_code = '0;
        for (int c = 0; c < 8; c++) begin
            occ_code[c] = |i_rd_data[PTR_W*c +: PTR_W];
        end
    end

    assign scan_ptr    = node_q[PTR_W*int'(scan_idx_q) +: PTR_W];
    assign scan_branch = (scan_ptr > PTR_W'(1));
    assign q_full      = (q_count_q == Q_FULL);
    assign q_empty     = (q_count_q == '0);
    assign push_en     = (state_q == SCAN) && scan_branch && !q_full;
    assign head_addr   = queue_mem[rd_ptr_q];

`ifdef OCTREE_BFS_VISITED_FILTER_EN
    assign head_seen = visited_q[head_addr];
`else
    assign head_seen = 1'b0;
`endif

    // Queue storage carries no reset so it can map onto RAM; only the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            queue_mem[wr_ptr_q] <= scan_ptr[ADDR_W-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            node_q        <= '0;
            scan_idx_q    <= '0;
            wait_cnt_q    <= '0;
            pack_q        <= '0;
            pack_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            q_count_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            burst_data_q  <= '0;
            burst_valid_q <= 1'b0;
            burst_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            node_count_q  <= '0;
`ifdef OCTREE_BFS_VISITED_FILTER_EN
            visited_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        overflow_q   <= 1'b0;
                        node_count_q <= '0;
                        pack_q       <= '0;
                        pack_cnt_q   <= '0;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        q_count_q    <= '0;
                        busy_q       <= 1'b1;
`ifdef OCTREE_BFS_VISITED_FILTER_EN
                        visited_q    <= '0;
`endif
                        if (i_root_addr > ADDR_W'(1)) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= i_root_addr;
                            state_q   <= FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                FETCH: begin
                    rd_en_q    <= 1'b0;
                    wait_cnt_q <= LAT_W'(1);
                    state_q    <= WAIT;
`ifdef OCTREE_BFS_VISITED_FILTER_EN
                    visited_q[rd_addr_q] <= 1'b1;
`endif
                end

                // The last WAIT cycle is the one where the BRAM word is valid.
                WAIT: begin
                    if (wait_cnt_q == LAT_LAST) begin
                        node_q <= i_rd_data;
                        for (int s = 0; s < NCODES; s++) begin
                            if (pack_cnt_q == CNT_W'(s)) begin
                                pack_q[BURST_W-1-8*s -: 8] <= occ_code;
                            end
                        end
                        pack_cnt_q <= pack_cnt_q + 1'b1;
                        if (node_count_q != 16'hFFFF) begin
                            node_count_q <= node_count_q + 16'd1;
                        end
                        scan_idx_q <= 3'd7;
                        state_q    <= SCAN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                SCAN: begin
                    if (push_en) begin
                        wr_ptr_q  <= wr_ptr_q + 1'b1;
                        q_count_q <= q_count_q + 1'b1;
                    end else if (scan_branch) begin
                        overflow_q <= 1'b1;
                    end
                    if (scan_idx_q == 3'd0) begin
                        state_q <= POP;
                    end else begin
                        scan_idx_q <= scan_idx_q - 3'd1;
                    end
                end

                // A full pack register waits here until we know whether another code follows,
                // so the final burst of the traversal can always carry the last flag.
                POP: begin
                    if (q_empty) begin
                        if (pack_cnt_q != '0) begin
                            burst_data_q  <= pack_q;
                            burst_valid_q <= 1'b1;
                            burst_last_q  <= 1'b1;
                            state_q       <= FLUSH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (head_seen) begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        q_count_q <= q_count_q - 1'b1;
                    end else if (pack_cnt_q == PACK_FULL) begin
                        burst_data_q  <= pack_q;
                        burst_valid_q <= 1'b1;
                        burst_last_q  <= 1'b0;
                        state_q       <= FLUSH;
                    end else begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        q_count_q <= q_count_q - 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= head_addr;
                        state_q   <= FETCH;
                    end
                end

                FLUSH: begin
                    if (i_burst_ready) begin
                        burst_valid_q <= 1'b0;
                        burst_last_q  <= 1'b0;
                        burst_data_q  <= '0;
                        pack_q        <= '0;
                        pack_cnt_q    <= '0;
                        if (burst_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= POP;
                        end
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_burst_data  = burst_data_q;
    assign o_burst_valid = burst_valid_q;
    assign o_burst_last  = burst_last_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_overflow    = overflow_q;
    assign o_node_count  = node_count_q;

endmodule

// File: tb/tb_octree_bfs_engine.sv
// Randomized bench for octree_bfs_engine: a queue-based BFS model predicts codes, bursts, counts and overflow.
// Two instances share one table: the default build and a QUEUE_DEPTH=4 build for overflow cases.
module tb_octree_bfs_engine;

    localparam int ADDR_W  = 9;
    localparam int PTR_W   = 16;
    localparam int BURST_W = 64;
    localparam int NCODES  = BURST_W / 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic burstReady;
    logic [ADDR_W-1:0] rootAddr;

    logic [8*PTR_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic               rdEnA, rdEnB;
    logic [ADDR_W-1:0]  rdAddrA, rdAddrB;
    logic [8*PTR_W-1:0] rdDataA, rdDataB;
    logic [BURST_W-1:0] burstDataA, burstDataB;
    logic               burstValidA, burstValidB;
    logic               burstLastA, burstLastB;
    logic               busyA, busyB;
    logic               doneA, doneB;
    logic               overflowA, overflowB;
    logic [15:0]        nodeCountA, nodeCountB;

    logic               oRdEn;
    logic [ADDR_W-1:0]  oRdAddr;
    logic [BURST_W-1:0] oBurstData;
    logic               oBurstValid, oBurstLast, oBusy, oDone, oOverflow;
    logic [15:0]        oNodeCount;

    int checks = 0;
    int passes = 0;

    byte unsigned expCodes[$];
    bit           expOvf;
    int           expFetches;

    always #5 clk = ~clk;

    octree_bfs_engine #(
        .ADDR_W(ADDR_W), .PTR_W(PTR_W), .BURST_W(BURST_W), .QUEUE_DEPTH(512), .BRAM_LAT(1)
    ) dutA (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .i_root_addr(rootAddr),
        .o_rd_en(rdEnA), .o_rd_addr(rdAddrA), .i_rd_data(rdDataA),
        .o_burst_data(burstDataA), .o_burst_valid(burstValidA), .i_burst_ready(burstReady & ~sel),
        .o_burst_last(burstLastA), .o_busy(busyA), .o_done(doneA),
        .o_overflow(overflowA), .o_node_count(nodeCountA)
    );

    octree_bfs_engine #(
        .ADDR_W(ADDR_W), .PTR_W(PTR_W), .BURST_W(BURST_W), .QUEUE_DEPTH(4), .BRAM_LAT(1)
    ) dutB (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel), .i_root_addr(rootAddr),
        .o_rd_en(rdEnB), .o_rd_addr(rdAddrB), .i_rd_data(rdDataB),
        .o_burst_data(burstDataB), .o_burst_valid(burstValidB), .i_burst_ready(burstReady & sel),
        .o_burst_last(burstLastB), .o_busy(busyB), .o_done(doneB),
        .o_overflow(overflowB), .o_node_count(nodeCountB)
    );

    // Single-cycle-latency BRAM read ports onto the shared branch table.
    always @(posedge clk) begin
        if (rdEnA) rdDataA <= mem[rdAddrA];
        if (rdEnB) rdDataB <= mem[rdAddrB];
    end

    assign oRdEn       = sel ? rdEnB       : rdEnA;
    assign oRdAddr     = sel ? rdAddrB     : rdAddrA;
    assign oBurstData  = sel ? burstDataB  : burstDataA;
    assign oBurstValid = sel ? burstValidB : burstValidA;
    assign oBurstLast  = sel ? burstLastB  : burstLastA;
    assign oBusy       = sel ? busyB       : busyA;
    assign oDone       = sel ? doneB       : doneA;
    assign oOverflow   = sel ? overflowB   : overflowA;
    assign oNodeCount  = sel ? nodeCountB  : nodeCountA;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clearMem();
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    endtask

    task automatic setPtr(input int addr, input int child, input logic [15:0] ptr);
        mem[addr][PTR_W*child +: PTR_W] = ptr;
    endtask

    // Plain BFS over the table: pop, fetch, record code, enqueue branch children 7..0 if room.
    task automatic modelRun(input int root, input int depth);
        int q[$];
        int a;
        logic [8*PTR_W-1:0] w;
        logic [15:0] p;
        byte unsigned code;
`ifdef OCTREE_BFS_VISITED_FILTER_EN
        bit vis[int];
`endif
        expCodes   = {};
        expOvf     = 1'b0;
        expFetches = 0;
        if (root >= 2) q.push_back(root);
        while (q.size() > 0) begin
            a = q.pop_front();
`ifdef OCTREE_BFS_VISITED_FILTER_EN
            if (vis.exists(a)) continue;
            vis[a] = 1'b1;
`endif
            expFetches++;
            w    = mem[a];
            code = 8'h00;
            for (int c = 7; c >= 0; c--) begin
                p = w[PTR_W*c +: PTR_W];
                if (p != 16'd0) code[c] = 1'b1;
                if (p >= 16'd2) begin
                    if (q.size() < depth) q.push_back(int'(p) % (1 << ADDR_W));
                    else expOvf = 1'b1;
                end
            end
            expCodes.push_back(code);
        end
    endtask

    task automatic buildRandomTree(input int maxNodes);
        int nextId;
        logic [15:0] p;
        logic [8*PTR_W-1:0] w;
        clearMem();
        nextId = 3;
        for (int a = 2; a < nextId; a++) begin
            w = '0;
            for (int c = 0; c < 8; c++) begin
                p = 16'd0;
                case ($urandom_range(0, 3))
                    0: p = 16'd0;
                    1: p = 16'd1;
                    default: begin
                        if (nextId < maxNodes + 2) begin
                            p = 16'(nextId);
                            if ($urandom_range(0, 3) == 0) p[15:9] = 7'($urandom_range(1, 127));
                            nextId++;
                        end else begin
                            p = 16'($urandom_range(0, 1));
                        end
                    end
                endcase
                w[PTR_W*c +: PTR_W] = p;
            end
            mem[a] = w;
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " rd_en"}, oRdEn, 0);
        checkOutput({name, " rd_addr"}, oRdAddr, 0);
        checkOutput({name, " burst_data"}, oBurstData, 0);
        checkOutput({name, " burst_valid"}, oBurstValid, 0);
        checkOutput({name, " burst_last"}, oBurstLast, 0);
        checkOutput({name, " busy"}, oBusy, 0);
        checkOutput({name, " done"}, oDone, 0);
        checkOutput({name, " overflow"}, oOverflow, 0);
        checkOutput({name, " node_count"}, oNodeCount, 0);
    endtask

    // One traversal: start, drive ready, collect bursts, then compare everything to the model.
    task automatic applyStimulus(input string name, input int root, input bit useB,
                                 input int holdCycles, input bit randReady, input bit pokeStart);
        int nExp, cyc, fetches, stallCnt, expCount;
        bit doneSeen, stalled, ready;
        logic [63:0] prevData, word;
        logic [63:0] gotData[$];
        bit gotLast[$];

        modelRun(root, useB ? 4 : 512);
        nExp     = (expCodes.size() + NCODES - 1) / NCODES;
        expCount = (expCodes.size() > 65535) ? 65535 : expCodes.size();

        @(negedge clk);
        sel = useB; rootAddr = ADDR_W'(root); start = 1'b1; burstReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, " busy after start"}, oBusy, 1);
        if (root >= 2) checkOutput({name, " first rd_en"}, oRdEn, 1);
        else checkOutput({name, " early done"}, oDone, 1);

        doneSeen = 0; stalled = 0; cyc = 0; fetches = 0; stallCnt = 0; prevData = '0;
        while (!doneSeen && cyc < 20000) begin
            if (stalled) begin
                checkOutput({name, " stall valid hold"}, oBurstValid, 1);
                checkOutput({name, " stall data hold"}, oBurstData, prevData);
            end
            if (oRdEn) fetches++;
            if (oDone) doneSeen = 1;
            if (oBurstValid && gotData.size() == 0 && stallCnt < holdCycles) begin
                ready = 0;
                stallCnt++;
            end else begin
                ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            burstReady = ready;
            if (oBurstValid && ready) begin
                gotData.push_back(oBurstData);
                gotLast.push_back(oBurstLast);
            end
            stalled  = oBurstValid && !ready;
            prevData = oBurstData;
            start    = pokeStart && !doneSeen && ($urandom_range(0, 39) == 0);
            if (start) rootAddr = ADDR_W'($urandom_range(0, 511));
            if (!doneSeen) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        burstReady = 1'b0;

        checkOutput({name, " done seen"}, doneSeen, 1);
        checkOutput({name, " node count"}, oNodeCount, expCount);
        checkOutput({name, " overflow"}, oOverflow, expOvf);
        checkOutput({name, " fetches"}, fetches, expFetches);
        checkOutput({name, " burst count"}, gotData.size(), nExp);
        for (int b = 0; b < nExp && b < gotData.size(); b++) begin
            word = '0;
            for (int k = 0; k < NCODES; k++) begin
                if (b*NCODES + k < expCodes.size()) word[63-8*k -: 8] = expCodes[b*NCODES + k];
            end
            checkOutput($sformatf("%s burst%0d data", name, b), gotData[b], word);
            checkOutput($sformatf("%s burst%0d last", name, b), gotLast[b], (b == nExp - 1));
        end
        @(negedge clk);
        checkOutput({name, " done one cycle"}, oDone, 0);
        checkOutput({name, " idle busy"}, oBusy, 0);
    endtask

    task automatic loadFirstScenario();
        clearMem();
        setPtr(2, 7, 16'd3);
        setPtr(2, 5, 16'd1);
        setPtr(2, 0, 16'd4);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; rootAddr = '0; burstReady = 1'b0;
        clearMem();
        repeat (3) @(negedge clk);
        checkReset("reset A");
        sel = 1'b1;
        #1 checkReset("reset B");
        sel = 1'b0;
        rst = 1'b0;

        $display("[TB] root 2 three-code tree");
        loadFirstScenario();
        applyStimulus("basic", 2, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] nine-node tree with stalled first flush");
        clearMem();
        for (int c = 0; c < 8; c++) setPtr(2, c, 16'(3 + c));
        applyStimulus("nine", 2, 1'b0, 20, 1'b0, 1'b0);

        $display("[TB] shared child");
        clearMem();
        setPtr(2, 7, 16'd3);
        setPtr(2, 6, 16'd4);
        setPtr(3, 0, 16'd5);
        setPtr(4, 0, 16'd5);
        applyStimulus("dag", 2, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] overflow on shallow queue");
        clearMem();
        for (int c = 0; c < 8; c++) setPtr(2, c, 16'(3 + c));
        applyStimulus("ovf", 2, 1'b1, 0, 1'b0, 1'b0);
        loadFirstScenario();
        applyStimulus("ovf cleared", 2, 1'b1, 0, 1'b0, 1'b0);

        $display("[TB] reset during scan");
        loadFirstScenario();
        @(negedge clk);
        sel = 1'b0; rootAddr = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 checkReset("mid reset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("after reset", 2, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] degenerate roots");
        applyStimulus("root1", 1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("root0", 0, 1'b1, 0, 1'b0, 1'b0);

        $display("[TB] random trees");
        for (int t = 0; t < 12; t++) begin
            buildRandomTree($urandom_range(1, 50));
            applyStimulus($sformatf("rand%0d", t), 2, (t % 4 == 3), $urandom_range(0, 5), 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
